// File: rtl/fault_detection_collector_pkg.sv
// Shared types and width helpers for the systolic-array fault diagnosis blocks.
package strait_diag_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    CLASSIFY,
    WRITE,
    DONE
  } diag_state_t;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fault_detection_collector_if.sv
// Compare-result input bus and eNVM write-port outputs of the fault collector.
interface fault_detection_collector_if #(
  parameter int SYSTOLIC_SIZE = 8
);
  import strait_diag_pkg::*;

  localparam int ADDR_WIDTH = addr_width(SYSTOLIC_SIZE);

  logic                     cmp_valid;
  logic [ADDR_WIDTH-1:0]    cmp_row;
  logic [SYSTOLIC_SIZE-1:0] cmp_mismatch;
  logic                     test_done;

  logic                     detection_en;
  logic [ADDR_WIDTH-1:0]    detection_addr;
  logic [SYSTOLIC_SIZE-1:0] single_pe_detection;
  logic [SYSTOLIC_SIZE-1:0] row_fault_detection;
  logic [SYSTOLIC_SIZE-1:0] column_fault_detection;

  modport master (
    output cmp_valid, cmp_row, cmp_mismatch, test_done,
    input  detection_en, detection_addr, single_pe_detection,
           row_fault_detection, column_fault_detection
  );

  modport slave (
    input  cmp_valid, cmp_row, cmp_mismatch, test_done,
    output detection_en, detection_addr, single_pe_detection,
           row_fault_detection, column_fault_detection
  );

endinterface

// File: rtl/fault_detection_collector_popcount.sv
// Counts the set bits of one fault-map line.
module line_popcount #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic [WIDTH-1:0]     vec,
  output logic [CNT_WIDTH-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CNT_WIDTH'(vec[i]);
    end
  end

endmodule

// File: rtl/fault_detection_collector.sv
// Accumulates per-PE mismatches, classifies row/column/single-PE faults and
// streams the diagnosis into the eNVM one row per cycle.
module fault_detection_collector
  import strait_diag_pkg::*;
#(
  parameter int SYSTOLIC_SIZE  = 8,
  parameter int LINE_THRESHOLD = SYSTOLIC_SIZE / 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic diag_done,
  fault_detection_collector_if.slave bus
);

  localparam int N          = SYSTOLIC_SIZE;
  localparam int ADDR_WIDTH = addr_width(N);
  localparam int CNT_WIDTH  = cnt_width(N);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = CNT_WIDTH'(N);

  diag_state_t           state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] idx_next;
  logic [N-1:0]          fault_map [N];
  logic [CNT_WIDTH-1:0]  col_cnt   [N];
  logic [CNT_WIDTH-1:0]  col_next  [N];
  logic [N-1:0]          row_flag;
  logic [N-1:0]          col_flag;
  logic [N-1:0]          row_flag_next;
  logic [N-1:0]          col_flag_next;
  logic [N-1:0]          single_next;
  logic [N-1:0]          first_single;
  logic [CNT_WIDTH-1:0]  row_cnt;
  logic                  start_ok;

  line_popcount #(
    .WIDTH     (N),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_row_popcount (
    .vec   (fault_map[idx]),
    .count (row_cnt)
  );

  assign start_ok = start && (state == IDLE || state == DONE);

  // The *_next values fold in the row being classified this cycle, so the
  // first eNVM word can be registered on the final CLASSIFY edge.
  always_comb begin
    idx_next           = idx + ADDR_WIDTH'(1);
    row_flag_next      = row_flag;
    row_flag_next[idx] = int'(row_cnt) >= LINE_THRESHOLD;
    col_flag_next      = '0;
    for (int c = 0; c < N; c++) begin
      col_next[c] = (fault_map[idx][c] && col_cnt[c] != CNT_MAX) ?
                    col_cnt[c] + CNT_WIDTH'(1) : col_cnt[c];
      col_flag_next[c] = int'(col_next[c]) >= LINE_THRESHOLD;
    end
    single_next  = row_flag[idx_next] ? '0 : (fault_map[idx_next] & ~col_flag);
    first_single = row_flag_next[0] ? '0 : (fault_map[0] & ~col_flag_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      row_flag  <= '0;
      col_flag  <= '0;
      busy      <= 1'b0;
      diag_done <= 1'b0;
      for (int r = 0; r < N; r++) begin
        fault_map[r] <= '0;
        col_cnt[r]   <= '0;
      end
      bus.detection_en           <= 1'b0;
      bus.detection_addr         <= '0;
      bus.single_pe_detection    <= '0;
      bus.row_fault_detection    <= '0;
      bus.column_fault_detection <= '0;
    end else if (start_ok) begin
      state     <= COLLECT;
      idx       <= '0;
      row_flag  <= '0;
      col_flag  <= '0;
      busy      <= 1'b1;
      diag_done <= 1'b0;
      for (int r = 0; r < N; r++) begin
        fault_map[r] <= '0;
        col_cnt[r]   <= '0;
      end
      bus.detection_en           <= 1'b0;
      bus.detection_addr         <= '0;
      bus.single_pe_detection    <= '0;
      bus.row_fault_detection    <= '0;
      bus.column_fault_detection <= '0;
    end else begin
      unique case (state)
        IDLE: ;
        COLLECT: begin
          if (bus.cmp_valid && int'(bus.cmp_row) < N) begin
            fault_map[bus.cmp_row] <= fault_map[bus.cmp_row] | bus.cmp_mismatch;
          end
          if (bus.test_done) begin
            state <= CLASSIFY;
            idx   <= '0;
          end
        end
        CLASSIFY: begin
          row_flag <= row_flag_next;
          for (int c = 0; c < N; c++) begin
            col_cnt[c] <= col_next[c];
          end
          if (idx == LAST_IDX) begin
            col_flag                   <= col_flag_next;
            idx                        <= '0;
            state                      <= WRITE;
            bus.detection_en           <= 1'b1;
            bus.detection_addr         <= '0;
            bus.single_pe_detection    <= first_single;
            bus.row_fault_detection    <= row_flag_next;
            bus.column_fault_detection <= col_flag_next;
          end else begin
            idx <= idx_next;
          end
        end
        WRITE: begin
          if (idx == LAST_IDX) begin
            state                   <= DONE;
            busy                    <= 1'b0;
            diag_done               <= 1'b1;
            bus.detection_en        <= 1'b0;
            bus.single_pe_detection <= '0;
          end else begin
            idx                     <= idx_next;
            bus.detection_addr      <= idx_next;
            bus.single_pe_detection <= single_next;
          end
        end
        DONE: begin
          diag_done <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
